// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by the instruction sequencer files: the FSM state
// encoding and the two opcodes the sequencer handles itself instead of
// issuing them to the datapath.
// Optional feature macro: SEQ_STEP_EN adds the PAUSE state (single-step mode).
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
`ifdef SEQ_STEP_EN
        ST_PAUSE = 3'd4,
`endif
        ST_HALT  = 3'd3
    } seq_state_e;

    // Instruction layout: opcode in [7:4], operand in [3:0].
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hD;

endpackage

// File: rtl/instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// instr_sequencer_if
// Groups every non-clock signal of the sequencer.
//   master : host/datapath side (drives load, control, issue_ready, done_ack)
//   slave  : sequencer side
// Signals:
//   load_valid/load_data/load_ready  program word load handshake
//   start/abort/clear                run control
//   issue_valid/issue_instr/issue_ready/done_ack  datapath issue handshake
//   busy/halted/err_overflow/pc/count             status
//   step (only with SEQ_STEP_EN)                  advance from PAUSE
// -----------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int IW    = 8
) ();
    localparam int PW = $clog2(DEPTH);

    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_ready;
    logic          start;
    logic          abort;
    logic          clear;
    logic          issue_valid;
    logic [IW-1:0] issue_instr;
    logic          issue_ready;
    logic          done_ack;
    logic          busy;
    logic          halted;
    logic          err_overflow;
    logic [PW-1:0] pc;
    logic [PW:0]   count;
`ifdef SEQ_STEP_EN
    logic          step;
`endif

    modport master (
        output load_valid, load_data, start, abort, clear, issue_ready, done_ack,
        input  load_ready, issue_valid, issue_instr, busy, halted, err_overflow, pc, count
`ifdef SEQ_STEP_EN
        , output step
`endif
    );

    modport slave (
        input  load_valid, load_data, start, abort, clear, issue_ready, done_ack,
        output load_ready, issue_valid, issue_instr, busy, halted, err_overflow, pc, count
`ifdef SEQ_STEP_EN
        , input step
`endif
    );

endinterface

// File: rtl/seq_prog_buf.sv
// -----------------------------------------------------------------------------
// seq_prog_buf
// Program buffer: one synchronous write port, one asynchronous read port.
// Ports:
//   i_clk          clock
//   i_we           write enable
//   i_waddr        write index
//   i_wdata        write data
//   i_raddr        read index
//   o_rdata        combinational read data
// -----------------------------------------------------------------------------
module seq_prog_buf #(
    parameter  int DEPTH = 16,
    parameter  int IW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; valid entries are tracked by the owner's
    // count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Loads a small program into a buffer while idle, then on start issues the
// words one at a time to a datapath, waiting for done_ack after each accepted
// instruction. HALT and JMP opcodes are executed locally and never issued.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     instr_sequencer_if.slave (load, control, issue, status signals)
// Optional feature macro: SEQ_STEP_EN -- after each non-last instruction the
// sequencer parks in PAUSE until bus.step is asserted.
// -----------------------------------------------------------------------------
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.slave   bus
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PC_ONE   = PW'(1);

    seq_state_e    r_state, w_next_state;
    logic [PW-1:0] r_pc, w_next_pc;
    logic [PW:0]   r_count, w_next_count;
    logic          r_err, w_next_err;
    logic          w_we;
    logic [IW-1:0] w_rd_instr;
    logic [3:0]    w_opcode;
    logic [PW-1:0] w_jmp_pc;
    logic          w_last;
    logic          w_issue_valid;

    seq_prog_buf #(.DEPTH(DEPTH), .IW(IW)) u_buf (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_count[PW-1:0]),
        .i_wdata (bus.load_data),
        .i_raddr (r_pc),
        .o_rdata (w_rd_instr)
    );

    assign w_opcode = w_rd_instr[7:4];
    // Operand reduced modulo DEPTH (DEPTH is a power of two).
    assign w_jmp_pc = PW'(w_rd_instr[3:0]);
    assign w_last   = ({1'b0, r_pc} == (r_count - CNT_ONE));

    // Issue is offered regardless of abort: a same-cycle handshake still
    // completes at the datapath, the sequencer just stops tracking it.
    assign w_issue_valid = (r_state == ST_ISSUE) &&
                           (w_opcode != OP_HALT) && (w_opcode != OP_JMP);

    // NOTE: every next-state variable gets a default before the case so that
    // no path leaves one unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_count = r_count;
        w_next_err   = r_err;
        w_we         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.clear) begin
                    w_next_count = '0;
                    w_next_err   = 1'b0;
                end else if (bus.load_valid) begin
                    if (r_count < CNT_FULL) begin
                        w_we         = 1'b1;
                        w_next_count = r_count + CNT_ONE;
                    end else begin
                        w_next_err   = 1'b1;
                    end
                end
                if (bus.start && !bus.clear && (r_count != '0)) begin
                    w_next_state = ST_ISSUE;
                    w_next_pc    = '0;
                end
            end

            ST_ISSUE: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                    w_next_pc    = '0;
                end else if (w_opcode == OP_HALT) begin
                    w_next_state = ST_HALT;
                end else if (w_opcode == OP_JMP) begin
                    w_next_pc    = w_jmp_pc;
                end else if (bus.issue_ready) begin
                    w_next_state = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                    w_next_pc    = '0;
                end else if (bus.done_ack) begin
                    if (w_last) begin
                        w_next_state = ST_HALT;
                    end else begin
`ifdef SEQ_STEP_EN
                        w_next_state = ST_PAUSE;
`else
                        w_next_state = ST_ISSUE;
                        w_next_pc    = r_pc + PC_ONE;
`endif
                    end
                end
            end

`ifdef SEQ_STEP_EN
            ST_PAUSE: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                    w_next_pc    = '0;
                end else if (bus.step) begin
                    w_next_state = ST_ISSUE;
                    w_next_pc    = r_pc + PC_ONE;
                end
            end
`endif

            ST_HALT: begin
                if (bus.abort) begin
                    w_next_state = ST_IDLE;
                    w_next_pc    = '0;
                end else if (bus.start) begin
                    w_next_state = ST_ISSUE;
                    w_next_pc    = '0;
                end else if (bus.clear) begin
                    w_next_state = ST_IDLE;
                    w_next_count = '0;
                    w_next_err   = 1'b0;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_count <= w_next_count;
            r_err   <= w_next_err;
        end
    end

    assign bus.load_ready   = (r_state == ST_IDLE) && (r_count < CNT_FULL);
    assign bus.issue_valid  = w_issue_valid;
    assign bus.issue_instr  = w_rd_instr;
    assign bus.halted       = (r_state == ST_HALT);
    assign bus.err_overflow = r_err;
    assign bus.pc           = r_pc;
    assign bus.count        = r_count;
`ifdef SEQ_STEP_EN
    assign bus.busy = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_PAUSE);
`else
    assign bus.busy = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
`endif

endmodule
